// File: rtl/servo_pwm_pkg.sv
// Shared servo PWM constants and the pulse-width clamp, also used by the sequencer.
package servo_pwm_pkg;

    localparam int unsigned DEF_PERIOD_CYC = 1_000_000;
    localparam int unsigned DEF_MIN_CYC    = 100_000;
    localparam int unsigned DEF_MAX_CYC    = 200_000;

    // Zero keeps the channel off; any other request is forced into [lo, hi].
    function automatic logic [31:0] clamp_width(input logic [31:0] v,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        logic [31:0] r;
        r = v;
        if (v == '0)
            r = '0;
        else if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        return r;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: double-buffered width (shadow -> active) and registered compare.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned MIN_CYC = DEF_MIN_CYC,
    parameter int unsigned MAX_CYC = DEF_MAX_CYC
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             transfer,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] count_nxt,
    output logic             pwm
);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] active_nxt;
    logic [CNT_W-1:0] wr_clamped;

    always_comb begin
        wr_clamped = CNT_W'(clamp_width(32'(wr_data), 32'(MIN_CYC), 32'(MAX_CYC)));
        // Transfer reads the pre-write shadow, so a write on the wrap edge waits a frame.
        active_nxt = transfer ? shadow : active;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en)
                shadow <= wr_clamped;
            active <= active_nxt;
            pwm    <= en & (count_nxt < active_nxt);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter, write decode and per-channel generators.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned MIN_CYC    = DEF_MIN_CYC,
    parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
    localparam int unsigned CNT_W     = $clog2(PERIOD_CYC),
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_data,
    output logic             wr_err,
    output logic [N_CH-1:0]  pwm_out,
    output logic             frame_start,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);
    localparam int unsigned CH_SPAN   = 1 << CH_W;

    logic             en_r;
    logic             wrap;
    logic             transfer;
    logic             wr_bad;
    logic [CNT_W-1:0] count_nxt;

    // Outputs are registered from next-state values so they line up with count.
    always_comb begin
        wrap      = (count == LAST);
        transfer  = ~en | wrap;
        count_nxt = '0;
        if (en && en_r && !wrap)
            count_nxt = count + CNT_W'(1);
    end

    generate
        if (N_CH < CH_SPAN) begin : g_range_chk
            assign wr_bad = (wr_ch >= CH_W'(N_CH));
        end else begin : g_no_range_chk
            assign wr_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count       <= '0;
            en_r        <= 1'b0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            count       <= count_nxt;
            en_r        <= en;
            frame_start <= en & (count_nxt == '0);
            wr_err      <= wr_en & wr_bad;
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            servo_pwm_channel #(
                .CNT_W   (CNT_W),
                .MIN_CYC (MIN_CYC),
                .MAX_CYC (MAX_CYC)
            ) u_ch (
                .clk       (clk),
                .clr_n     (clr_n),
                .en        (en),
                .transfer  (transfer),
                .wr_en     (wr_en && (wr_ch == CH_W'(i))),
                .wr_data   (wr_data),
                .count_nxt (count_nxt),
                .pwm       (pwm_out[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: per-cycle reference model plus width table and corner sequences.
module tb_servo_pwm_multi;

    localparam int P    = 100;
    localparam int N    = 3;   // three channels so that wr_ch = 3 is out of range with a 2-bit index
    localparam int MINC = 10;
    localparam int MAXC = 20;
    localparam int CW   = $clog2(P);
    localparam int HW   = 2;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          en;
    logic          wr_en;
    logic [HW-1:0] wr_ch;
    logic [CW-1:0] wr_data;
    logic          wr_err;
    logic [N-1:0]  pwm_out;
    logic          frame_start;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .PERIOD_CYC (P),
        .N_CH       (N),
        .MIN_CYC    (MINC),
        .MAX_CYC    (MAXC)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .count       (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the frame plus buffered widths.
    bit m_run;
    int m_pos;
    int m_shadow[N];
    int m_active[N];
    bit m_err;

    typedef struct {
        int ch;
        int data;
        int exp_w;
    } vec_t;
    vec_t tbl[11];

    function automatic int clamp_ref(input int v);
        if (v == 0)    return 0;
        if (v < MINC)  return MINC;
        if (v > MAXC)  return MAXC;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit boundary;
        boundary = !en || (m_pos == P - 1);
        if (boundary)
            for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        m_err = wr_en && (int'(wr_ch) >= N);
        if (wr_en && int'(wr_ch) < N)
            m_shadow[wr_ch] = clamp_ref(int'(wr_data));
        if (!en || !m_run)
            m_pos = 0;
        else
            m_pos = (m_pos + 1) % P;
        m_run = en;
    endtask

    task automatic check_outputs();
        check("count", int'(count), m_pos);
        check("frame_start", int'(frame_start), int'(m_run && m_pos == 0));
        check("wr_err", int'(wr_err), int'(m_err));
        for (int i = 0; i < N; i++)
            check($sformatf("pwm%0d", i), int'(pwm_out[i]), int'(m_run && m_pos < m_active[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = HW'(ch);
        wr_data = CW'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_count(input int c);
        int k;
        k = 0;
        while (int'(count) != c && k < 3 * P) begin
            tick();
            k++;
        end
        if (int'(count) != c) fail_timeout("wait_count");
    endtask

    task automatic measure(input int ch, output int width, output bit first_hi);
        int k;
        k = 0;
        while (!frame_start && k < 3 * P) begin
            tick();
            k++;
        end
        if (!frame_start) fail_timeout("wait_frame_start");
        width    = 0;
        first_hi = pwm_out[ch];
        for (int j = 0; j < P; j++) begin
            if (pwm_out[ch]) width++;
            tick();
        end
    endtask

    initial begin
        int w;
        bit fh;
        int cnt;

        tbl[0]  = '{1, 5, 10};
        tbl[1]  = '{1, 50, 20};
        tbl[2]  = '{1, 0, 0};
        tbl[3]  = '{2, 1, 10};
        tbl[4]  = '{2, 127, 20};
        tbl[5]  = '{2, 20, 20};
        tbl[6]  = '{0, 9, 10};
        tbl[7]  = '{0, 21, 20};
        tbl[8]  = '{0, 10, 10};
        tbl[9]  = '{0, 15, 15};
        tbl[10] = '{1, 17, 17};

        clr_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check("reset_pwm", int'(pwm_out), 0);
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Idle frames: two frame starts in 200 cycles, no pulses.
        en  = 1'b1;
        cnt = 0;
        w   = 0;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            if (frame_start) cnt++;
            if (pwm_out != '0) w++;
        end
        check("idle_frame_starts", cnt, 2);
        check("idle_pwm_cycles", w, 0);

        // Clamp and width table: write mid-frame, measure the next frame.
        foreach (tbl[t]) begin
            wait_count(40);
            write(tbl[t].ch, tbl[t].data);
            measure(tbl[t].ch, w, fh);
            check($sformatf("width_v%0d", t), w, tbl[t].exp_w);
            check($sformatf("start_v%0d", t), int'(fh), int'(tbl[t].exp_w > 0));
        end

        // Write on the last cycle of a frame: old value for one more frame.
        wait_count(P - 1);
        write(0, 12);
        measure(0, w, fh);
        check("wrap_write_old", w, 15);
        measure(0, w, fh);
        check("wrap_write_new", w, 12);

        // Out-of-range channel write.
        wait_count(30);
        write(3, 7);
        check("wr_err_pulse", int'(wr_err), 1);
        tick();
        check("wr_err_clear", int'(wr_err), 0);
        measure(0, w, fh);
        check("after_err_ch0", w, 12);

        // Asynchronous reset mid-pulse.
        wait_count(5);
        check("pulse_before_reset", int'(pwm_out[0]), 1);
        #2 clr_n = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_out), 0);
        check("async_rst_count", int'(count), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        clr_n = 1'b1;
        w = 0;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            if (pwm_out != '0) w++;
        end
        check("post_reset_pwm_cycles", w, 0);

        // Randomized traffic including en drops.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_ch   = HW'($urandom_range(0, 3));
            wr_data = CW'($urandom_range(0, 127));
            tick();
        end
        wr_en = 1'b0;
        en    = 1'b0;
        tick();
        check("en_off_pwm", int'(pwm_out), 0);
        check("en_off_fs", int'(frame_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
